imem_loader: RTL and testbench

Program loader that writes the instruction words of a test program into the processor's instruction memory over a valid/ready stream. It holds the pipelined processor in reset while it loads, then releases it. It is the writing side of the instruction-memory read path, and replaces file-based preloading in top-level benches and on hardware.

---
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Streams a program into instruction memory while holding the processor in reset, then releases it.
// Optional feature: LOADER_CHECKSUM_EN treats the in_last word as a checksum of the written words.
module imem_loader #(
    parameter int unsigned DataWidth   = 16,
    parameter int unsigned AddrBits    = 8,
    parameter int unsigned FlushCycles = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [DataWidth-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 imem_we,
    output logic [AddrBits-1:0]  imem_addr,
    output logic [DataWidth-1:0] imem_wdata,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 error,
    output logic [AddrBits:0]    word_count
);

    localparam int unsigned CountW = AddrBits + 1;
    localparam int unsigned FlushW = 4;
    localparam logic [AddrBits-1:0] LastAddr = '1;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, ERROR} state_t;

    state_t                state, state_n;
    logic [AddrBits-1:0]   ptr, ptr_n;
    logic [CountW-1:0]     word_count_n;
    logic [FlushW-1:0]     flush_cnt, flush_cnt_n;
    logic                  imem_we_n;
    logic [AddrBits-1:0]   imem_addr_n;
    logic [DataWidth-1:0]  imem_wdata_n;
    logic                  xfer, wr, sum_ok;
`ifdef LOADER_CHECKSUM_EN
    logic [DataWidth-1:0]  sum, sum_n;
`endif

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            ptr        <= '0;
            word_count <= '0;
            flush_cnt  <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            word_count <= word_count_n;
            flush_cnt  <= flush_cnt_n;
            in_ready   <= (state_n == LOAD);
            imem_we    <= imem_we_n;
            imem_addr  <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            cpu_rst    <= (state_n != RUN);
            done       <= (state_n == RUN);
            error      <= (state_n == ERROR);
`ifdef LOADER_CHECKSUM_EN
            sum        <= sum_n;
`endif
        end
    end

    // Next-state, pointer and write-port logic
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        word_count_n = word_count;
        flush_cnt_n  = flush_cnt;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        xfer         = in_valid & in_ready;
`ifdef LOADER_CHECKSUM_EN
        sum_n        = sum;
        wr           = xfer & ~in_last;
        sum_ok       = (in_data == sum);
`else
        wr           = xfer;
        sum_ok       = 1'b1;
`endif

        case (state)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    state_n      = LOAD;
                    ptr_n        = '0;
                    word_count_n = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_n        = '0;
`endif
                end
            end
            LOAD: begin
                if (wr) begin
                    imem_we_n    = 1'b1;
                    imem_addr_n  = ptr;
                    imem_wdata_n = in_data;
                    ptr_n        = ptr + AddrBits'(1);
                    word_count_n = word_count + CountW'(1);
`ifdef LOADER_CHECKSUM_EN
                    sum_n        = sum + in_data;
`endif
                end
                // Overflow only when the final address is written by a non-last word
                if (xfer && in_last) begin
                    state_n     = sum_ok ? FLUSH : ERROR;
                    flush_cnt_n = '0;
                end else if (wr && (ptr == LastAddr)) begin
                    state_n = ERROR;
                end
            end
            FLUSH: begin
                if (flush_cnt == FlushW'(FlushCycles)) begin
                    state_n = RUN;
                end else begin
                    flush_cnt_n = flush_cnt + FlushW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader: a wide and a tiny (3-bit address) instance
// share one stimulus stream and are checked every cycle against an event-level reference model.
module tb_imem_loader;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW0 = 8;
    localparam int unsigned AW1 = 3;
    localparam int unsigned FC  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_FLUSH = 2;
    localparam int M_RUN   = 3;
    localparam int M_ERR   = 4;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [DW-1:0] in_data  = '0;

    logic           rdy0, we0, crst0, done0, err0;
    logic [AW0-1:0] addr0;
    logic [DW-1:0]  wdata0;
    logic [AW0:0]   wc0;
    logic           rdy1, we1, crst1, done1, err1;
    logic [AW1-1:0] addr1;
    logic [DW-1:0]  wdata1;
    logic [AW1:0]   wc1;

    imem_loader #(.DataWidth(DW), .AddrBits(AW0), .FlushCycles(FC)) dut0 (
        .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy0), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wdata0), .cpu_rst(crst0), .done(done0), .error(err0), .word_count(wc0)
    );

    imem_loader #(.DataWidth(DW), .AddrBits(AW1), .FlushCycles(FC)) dut1 (
        .CLK(CLK), .RST(RST), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(rdy1), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(wdata1), .cpu_rst(crst1), .done(done1), .error(err1), .word_count(wc1)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one entry per instance
    int          depth[2] = '{256, 8};
    int          m_mode[2];
    int          m_ptr[2];
    int          m_wc[2];
    int          m_fl[2];
    int unsigned m_sum[2];
    bit          e_rdy[2], e_we[2], e_crst[2], e_done[2], e_err[2];
    int          e_addr[2], e_wdata[2];
    bit          mvalid = 1'b0;

    task automatic model_step(input int k);
        bit acc, is_word, ok;
        if (!RST) begin
            m_mode[k] = M_IDLE; m_ptr[k] = 0; m_wc[k] = 0; m_sum[k] = 0;
            e_we[k] = 1'b0; e_addr[k] = 0; e_wdata[k] = 0;
        end else begin
            acc = e_rdy[k] && in_valid;
            e_we[k] = 1'b0;
            case (m_mode[k])
                M_IDLE, M_RUN, M_ERR: if (start) begin
                    m_mode[k] = M_LOAD; m_ptr[k] = 0; m_wc[k] = 0; m_sum[k] = 0;
                end
                M_LOAD: if (acc) begin
                    is_word = 1'b1;
                    ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    if (in_last) is_word = 1'b0;
                    ok = (int'(in_data) == int'(m_sum));
`endif
                    if (is_word) begin
                        e_we[k] = 1'b1; e_addr[k] = m_ptr[k]; e_wdata[k] = int'(in_data);
                        m_sum[k] = (m_sum[k] + in_data) & 32'hFFFF;
                        m_wc[k]++;
                    end
                    if (in_last) begin
                        m_mode[k] = ok ? M_FLUSH : M_ERR;
                        m_fl[k] = 0;
                    end else if (m_ptr[k] == depth[k] - 1) begin
                        m_mode[k] = M_ERR;
                    end
                    if (is_word) m_ptr[k] = (m_ptr[k] + 1) % depth[k];
                end
                M_FLUSH: begin
                    m_fl[k]++;
                    if (m_fl[k] == FC + 1) m_mode[k] = M_RUN;
                end
                default: m_mode[k] = M_IDLE;
            endcase
        end
        e_rdy[k]  = (m_mode[k] == M_LOAD);
        e_crst[k] = (m_mode[k] != M_RUN);
        e_done[k] = (m_mode[k] == M_RUN);
        e_err[k]  = (m_mode[k] == M_ERR);
    endtask

    always @(posedge CLK) begin
        model_step(0);
        model_step(1);
        if (!RST) mvalid = 1'b1;
    end

    task automatic cmp(input int k, input bit rdy, input bit we, input int addr, input int wdata,
                       input bit crst, input bit dn, input bit err, input int wc);
        string p;
        p = (k == 0) ? "d0" : "d1";
        chk({p, " in_ready"}, rdy, e_rdy[k]);
        chk({p, " imem_we"}, we, e_we[k]);
        if (e_we[k]) begin
            chk({p, " imem_addr"}, addr, e_addr[k]);
            chk({p, " imem_wdata"}, wdata, e_wdata[k]);
        end
        chk({p, " cpu_rst"}, crst, e_crst[k]);
        chk({p, " done"}, dn, e_done[k]);
        chk({p, " error"}, err, e_err[k]);
        chk({p, " word_count"}, wc, m_wc[k]);
    endtask

    int cap0_a[$], cap0_d[$], cap1_a[$], cap1_d[$];

    // Per-cycle compare and write capture
    always @(negedge CLK) begin
        if (mvalid) begin
            cmp(0, rdy0, we0, int'(addr0), int'(wdata0), crst0, done0, err0, int'(wc0));
            cmp(1, rdy1, we1, int'(addr1), int'(wdata1), crst1, done1, err1, int'(wc1));
        end
        if (we0) begin cap0_a.push_back(int'(addr0)); cap0_d.push_back(int'(wdata0)); end
        if (we1) begin cap1_a.push_back(int'(addr1)); cap1_d.push_back(int'(wdata1)); end
    end

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // Present one word until the wide instance takes it
    task automatic send(input logic [DW-1:0] d, input bit last);
        bit r, taken;
        taken = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = last;
        for (int t = 0; t < 50; t++) begin
            r = rdy0;
            cyc();
            if (r) begin taken = 1'b1; break; end
        end
        if (!taken) chk("send timeout", 0, 1);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic clear_caps();
        cap0_a.delete(); cap0_d.delete(); cap1_a.delete(); cap1_d.delete();
    endtask

    logic [DW-1:0] bne_prog[7] = '{16'h4103, 16'h4203, 16'h4301, 16'h8A02,
                                   16'h4401, 16'h4400, 16'hF000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, abort_at, nw;
        logic [DW-1:0] d, sum;

        // Reset held two cycles with a word on offer
        RST = 1'b0; in_valid = 1'b1; in_data = 16'hBEEF;
        @(negedge CLK);
        cyc();
        chk("rst in_ready", rdy0, 0);
        chk("rst cpu_rst", crst0, 1);
        chk("rst done", done0, 0);
        chk("rst imem_we", we0, 0);
        chk("rst word_count", wc0, 0);
        chk("rst imem_addr", addr0, 0);
        RST = 1'b1; in_valid = 1'b0;
        cyc();
        chk("idle in_ready", rdy0, 0);

`ifndef LOADER_CHECKSUM_EN
        // Seven-word branch test program, no gaps
        clear_caps();
        pulse_start();
        chk("bne in_ready after start", rdy0, 1);
        for (int i = 0; i < 7; i++) send(bne_prog[i], i == 6);
        chk("bne word_count", wc0, 7);
        chk("bne in_ready low", rdy0, 0);
        cyc();
        cyc();
        chk("bne cpu_rst in flush", crst0, 1);
        cyc();
        chk("bne cpu_rst released", crst0, 0);
        chk("bne done", done0, 1);
        cyc();
        chk("bne writes", cap0_a.size(), 7);
        for (int i = 0; i < 7 && i < cap0_a.size(); i++) begin
            chk("bne addr", cap0_a[i], i);
            chk("bne data", cap0_d[i], int'(bne_prog[i]));
        end

        // Reload from RUN with gaps between words
        clear_caps();
        pulse_start();
        chk("reload cpu_rst", crst0, 1);
        chk("reload done", done0, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin cyc(); cyc(); end
            send(16'hA000 + 16'(i), i == 3);
        end
        repeat (FC + 2) cyc();
        chk("gap writes", cap0_a.size(), 4);
        for (int i = 0; i < 4 && i < cap0_a.size(); i++) begin
            chk("gap addr", cap0_a[i], i);
            chk("gap data", cap0_d[i], 32'hA000 + i);
        end
        chk("gap done", done0, 1);
`else
        // Matching checksum
        clear_caps();
        pulse_start();
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1);
        repeat (FC + 1) cyc();
        chk("csum ok done", done0, 1);
        chk("csum ok error", err0, 0);
        chk("csum ok word_count", wc0, 2);
        cyc();
        chk("csum ok writes", cap0_a.size(), 2);
        // Mismatching checksum
        pulse_start();
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0004, 1'b1);
        chk("csum bad error", err0, 1);
        chk("csum bad done", done0, 0);
        chk("csum bad cpu_rst", crst0, 1);
`endif

        // Overflow on the 3-bit instance
        repeat (FC + 2) cyc();
        clear_caps();
        pulse_start();
        in_valid = 1'b1; in_last = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_data = 16'h0100 + 16'(i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("ovf writes", cap1_a.size(), 8);
        for (int i = 0; i < 8 && i < cap1_a.size(); i++) begin
            chk("ovf addr", cap1_a[i], i);
            chk("ovf data", cap1_d[i], 32'h0100 + i);
        end
        chk("ovf error", err1, 1);
        chk("ovf in_ready", rdy1, 0);
        chk("ovf cpu_rst", crst1, 1);
        chk("ovf word_count", wc1, 8);
        pulse_start();
        chk("ovf start clears error", err1, 0);
        chk("ovf restart in_ready", rdy1, 1);
        send(16'h1234, 1'b1);
        repeat (FC + 3) cyc();

        // Abort mid-load
        pulse_start();
        for (int i = 0; i < 3; i++) send(16'h5550 + 16'(i), 1'b0);
        RST = 1'b0;
        cyc();
        chk("abort in_ready", rdy0, 0);
        chk("abort cpu_rst", crst0, 1);
        chk("abort word_count", wc0, 0);
        chk("abort imem_addr", addr0, 0);
        chk("abort imem_wdata", wdata0, 0);
        RST = 1'b1;
        cyc();

        // Random programs with gaps, stray starts and occasional aborts
        for (int p = 0; p < 150; p++) begin
            pulse_start();
            n = int'($urandom_range(1, 12));
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            sum = '0;
            for (int i = 0; i < n; i++) begin
                if (i == abort_at) begin
                    RST = 1'b0; cyc(); RST = 1'b1;
                    break;
                end
                nw = int'($urandom_range(0, 2));
                for (int g = 0; g < nw; g++) begin
                    if ($urandom_range(0, 7) == 0) start = 1'b1;
                    cyc();
                    start = 1'b0;
                end
                d = DW'($urandom);
`ifdef LOADER_CHECKSUM_EN
                if (i == n - 1 && $urandom_range(0, 1) == 1) d = sum;
`endif
                send(d, i == n - 1);
                sum = sum + d;
            end
            repeat (FC + 2 + int'($urandom_range(0, 3))) cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
